// File: rtl/uart_xcvr_cfg.sv
// ---------------------------------------------------------------------------
// uart_xcvr_cfg : UART transceiver with runtime configuration.
//   Runtime baud divisor, 5..8 data bits, none/even/odd parity, 1 or 2 stop
//   bits on TX. Internal TX and RX FIFOs with valid/ready handshakes,
//   per-frame parity/framing flags, sticky overrun, and a loopback mode that
//   re-transmits every good received frame.
//
// Ports
//   sys_clk, sys_nrst         clock, asynchronous active-low reset
//   cfg_div                   os_tick period = cfg_div+1 clocks, 16 ticks/bit
//   cfg_parity                00/01 none, 10 even, 11 odd
//   cfg_stop2                 two stop bits on TX
//   lp_mode                   loopback: good RX frames go into the TX FIFO
//   tx_en                     allow TX to start a new frame
//   tx_valid/tx_ready/tx_data TX FIFO write handshake
//   tx_busy                   frame in flight on TX
//   rx_valid/rx_ready/rx_data RX FIFO read handshake (first-word fall-through)
//   rx_perr, rx_ferr          flags of the head frame
//   rx_ovf, ovf_clr           sticky drop flag and its clear
//   TX, RX                    serial pins (RX is asynchronous)
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for FIFO data and tx_en
//   TX_START | start bit (low)
//   TX_DATA  | data bits, LSB first
//   TX_PAR   | parity bit
//   TX_STOP  | 16 or 32 os_ticks high
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | counting to mid start bit, high there -> glitch
//   RX_DATA  | sampling data bits every 16 os_ticks
//   RX_PAR   | sampling parity bit
//   RX_STOP  | sampling stop bit, then push the frame
// ---------------------------------------------------------------------------
module uart_xcvr_cfg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         sys_clk,
  input  logic         sys_nrst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  // Callers qualify wr/rd; a write on a full FIFO is only issued together
  // with a read, so the slot being written has already been consumed.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module uart_xcvr_cfg #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int DIV_W    = 16
) (
  input  logic              sys_clk,
  input  logic              sys_nrst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              lp_mode,
  input  logic              tx_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  input  logic              rx_ready,
  output logic              rx_ovf,
  input  logic              ovf_clr,
  output logic              TX,
  input  logic              RX
);
  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_PAR   = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic par_en;
  assign par_en = cfg_parity[1];

  // ---------------- oversampling tick ----------------
  logic [DIV_W-1:0] tick_cnt;
  logic             os_tick;

  // >= keeps the counter bounded if cfg_div is lowered while it runs
  assign os_tick = (tick_cnt >= cfg_div);

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) tick_cnt <= '0;
    else           tick_cnt <= os_tick ? '0 : tick_cnt + 1'b1;
  end

  // ---------------- FIFOs ----------------
  logic              tx_wr, tx_pop, tx_empty, tx_full;
  logic [DATA_W-1:0] tx_wdata, tx_rdata;
  logic              rx_wr, rx_pop, rx_empty, rx_full;
  logic [DATA_W+1:0] rx_wdata, rx_rdata;

  uart_xcvr_cfg_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .sys_clk (sys_clk),
    .sys_nrst(sys_nrst),
    .wr      (tx_wr),
    .wdata   (tx_wdata),
    .rd      (tx_pop),
    .rdata   (tx_rdata),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  uart_xcvr_cfg_fifo #(.W(DATA_W + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .sys_clk (sys_clk),
    .sys_nrst(sys_nrst),
    .wr      (rx_wr),
    .wdata   (rx_wdata),
    .rd      (rx_pop),
    .rdata   (rx_rdata),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  // ---------------- TX FSM ----------------
  logic [2:0]        tx_state;
  logic [4:0]        tx_tmr;
  logic [2:0]        tx_idx;
  logic [DATA_W-1:0] tx_shr;
  logic              tx_pbit;
  logic              tx_q;
  logic              tx_bit_end;

  assign tx_bit_end = os_tick && (tx_tmr == 5'd0);
  // Popping in the last STOP cycle chains frames with no idle gap.
  assign tx_pop = !tx_empty && tx_en &&
                  ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_idx   <= '0;
      tx_shr   <= '0;
      tx_pbit  <= 1'b0;
      tx_q     <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_tmr   <= 5'd15;
      tx_shr   <= tx_rdata;
      tx_pbit  <= (^tx_rdata) ^ cfg_parity[0];
      tx_q     <= 1'b0;
    end else if ((tx_state != TX_IDLE) && os_tick) begin
      if (tx_tmr != 5'd0) begin
        tx_tmr <= tx_tmr - 5'd1;
      end else begin
        tx_tmr <= 5'd15;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
            tx_q     <= tx_shr[0];
          end
          TX_DATA: begin
            if (tx_idx == LAST_BIT) begin
              if (par_en) begin
                tx_state <= TX_PAR;
                tx_q     <= tx_pbit;
              end else begin
                tx_state <= TX_STOP;
                tx_q     <= 1'b1;
                tx_tmr   <= cfg_stop2 ? 5'd31 : 5'd15;
              end
            end else begin
              tx_idx <= tx_idx + 3'd1;
              tx_shr <= tx_shr >> 1;
              tx_q   <= tx_shr[1];
            end
          end
          TX_PAR: begin
            tx_state <= TX_STOP;
            tx_q     <= 1'b1;
            tx_tmr   <= cfg_stop2 ? 5'd31 : 5'd15;
          end
          default: begin
            tx_state <= TX_IDLE;
            tx_q     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign TX      = tx_q;
  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------- RX FSM ----------------
  logic              rx_m, rx_s, rx_d;
  logic [2:0]        rx_state;
  logic [3:0]        rx_tmr;
  logic [2:0]        rx_idx;
  logic [DATA_W-1:0] rx_shr;
  logic              rx_perr_q;
  logic              rx_done;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_state  <= RX_IDLE;
      rx_tmr    <= '0;
      rx_idx    <= '0;
      rx_shr    <= '0;
      rx_perr_q <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      if (rx_d && !rx_s) begin
        rx_state <= RX_START;
        rx_tmr   <= 4'd7;
      end
    end else if (os_tick) begin
      if (rx_tmr != 4'd0) begin
        rx_tmr <= rx_tmr - 4'd1;
      end else begin
        rx_tmr <= 4'd15;
        case (rx_state)
          RX_START: begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state  <= RX_DATA;
              rx_idx    <= '0;
              rx_perr_q <= 1'b0;
            end
          end
          RX_DATA: begin
            rx_shr <= {rx_s, rx_shr[DATA_W-1:1]};
            if (rx_idx == LAST_BIT) rx_state <= par_en ? RX_PAR : RX_STOP;
            else                    rx_idx   <= rx_idx + 3'd1;
          end
          RX_PAR: begin
            rx_perr_q <= rx_s ^ (^rx_shr) ^ cfg_parity[0];
            rx_state  <= RX_STOP;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_done = (rx_state == RX_STOP) && os_tick && (rx_tmr == 4'd0);

  // ---------------- routing ----------------
  logic to_rx, to_lp, lp_wr, tx_ext_wr;

  assign to_rx     = rx_done && !lp_mode;
  assign to_lp     = rx_done && lp_mode && rx_s && !rx_perr_q;
  assign rx_pop    = !rx_empty && rx_ready;
  assign rx_wr     = to_rx && (!rx_full || rx_pop);
  assign rx_wdata  = {!rx_s, rx_perr_q, rx_shr};
  assign lp_wr     = to_lp && (!tx_full || tx_pop);
  assign tx_ready  = !tx_full && !lp_mode;
  assign tx_ext_wr = tx_valid && tx_ready;
  assign tx_wr     = tx_ext_wr || lp_wr;
  assign tx_wdata  = lp_wr ? rx_shr : tx_data;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst)                                rx_ovf <= 1'b0;
    else if ((to_rx && !rx_wr) || (to_lp && !lp_wr)) rx_ovf <= 1'b1;
    else if (ovf_clr)                             rx_ovf <= 1'b0;
  end

  assign rx_valid = !rx_empty;
  assign {rx_ferr, rx_perr, rx_data} = rx_valid ? rx_rdata : '0;
endmodule
